// File: rtl/usb_reg_bridge_if.sv
// Bundles the USB parallel-bus pins and the register-bus signals of usb_reg_bridge.
// Strobes: reg_read/reg_write are single-cycle pulses qualified by reg_addrvalid; there is no ready/back-pressure.
interface usb_reg_bridge_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int BCNT_WIDTH = 16
);
  logic [7:0]            usb_addr;
  logic [7:0]            usb_din;
  logic [7:0]            usb_dout;
  logic                  usb_isout;
  logic                  usb_rdn;
  logic                  usb_wrn;
  logic                  usb_cen;
  logic                  usb_alen;
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [BCNT_WIDTH-1:0] reg_bytecnt;
  logic [7:0]            reg_datao;
  logic [7:0]            reg_datai;
  logic                  reg_read;
  logic                  reg_write;
  logic                  reg_addrvalid;
  logic [ADDR_WIDTH-1:0] reg_hypaddress;
  logic [15:0]           reg_hyplen;
  logic [15:0]           reg_size;

  modport slave (
    input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, usb_alen, reg_datai, reg_hyplen,
    output usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao, reg_read, reg_write,
           reg_addrvalid, reg_hypaddress, reg_size
  );

  modport master (
    output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, usb_alen, reg_datai, reg_hyplen,
    input  usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao, reg_read, reg_write,
           reg_addrvalid, reg_hypaddress, reg_size
  );
endinterface

// File: rtl/usb_reg_bridge.sv
// Converts the asynchronous USB microcontroller strobe bus into single-clock register-bus
// strobes; all USB inputs are synchronised to clk_usb before use.
module usb_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 6,
  parameter int BCNT_WIDTH  = 16
) (
  input  logic             clk_usb,
  input  logic             reset_n,
  usb_reg_bridge_if.slave  bus,
  output logic [2:0]       dbg_state_o
);
  typedef enum logic [2:0] {IDLE, READY, WR_STB, RD_STB, RD_HOLD} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic rst_n_q;
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) rst_n_q <= 1'b0;
    else          rst_n_q <= 1'b1;
  end

  logic [SYNC_STAGES-1:0]      rdn_sync_q, wrn_sync_q, cen_sync_q, alen_sync_q;
  logic [SYNC_STAGES-1:0][7:0] addr_sync_q, din_sync_q;
  logic                        rdn_last_q, wrn_last_q;

  always_ff @(posedge clk_usb or negedge rst_n_q) begin
    if (!rst_n_q) begin
      rdn_sync_q  <= '1;
      wrn_sync_q  <= '1;
      cen_sync_q  <= '1;
      alen_sync_q <= '1;
      addr_sync_q <= '0;
      din_sync_q  <= '0;
      rdn_last_q  <= 1'b1;
      wrn_last_q  <= 1'b1;
    end else begin
      rdn_sync_q  <= {rdn_sync_q[SYNC_STAGES-2:0], bus.usb_rdn};
      wrn_sync_q  <= {wrn_sync_q[SYNC_STAGES-2:0], bus.usb_wrn};
      cen_sync_q  <= {cen_sync_q[SYNC_STAGES-2:0], bus.usb_cen};
      alen_sync_q <= {alen_sync_q[SYNC_STAGES-2:0], bus.usb_alen};
      addr_sync_q <= {addr_sync_q[SYNC_STAGES-2:0], bus.usb_addr};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.usb_din};
      rdn_last_q  <= rdn_sync_q[SYNC_STAGES-1];
      wrn_last_q  <= wrn_sync_q[SYNC_STAGES-1];
    end
  end

  logic       rdn_s, wrn_s, cen_s, alen_s;
  logic [7:0] addr_s, din_s;
  logic       rd_fall, rd_rise, wr_fall, wr_rise;
  logic       unused_addr_hi;

  assign rdn_s          = rdn_sync_q[SYNC_STAGES-1];
  assign wrn_s          = wrn_sync_q[SYNC_STAGES-1];
  assign cen_s          = cen_sync_q[SYNC_STAGES-1];
  assign alen_s         = alen_sync_q[SYNC_STAGES-1];
  assign addr_s         = addr_sync_q[SYNC_STAGES-1];
  assign din_s          = din_sync_q[SYNC_STAGES-1];
  assign rd_fall        = rdn_last_q & ~rdn_s;
  assign rd_rise        = ~rdn_last_q & rdn_s;
  assign wr_fall        = wrn_last_q & ~wrn_s;
  assign wr_rise        = ~wrn_last_q & wrn_s;
  assign unused_addr_hi = ^addr_s;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [15:0]           size_q, size_d;
  logic [7:0]            datao_q, datao_d, dout_q, dout_d;
  logic                  isout_q, isout_d, read_q, read_d, write_q, write_d;
  logic                  addrvalid_q, addrvalid_d, armed_q, armed_d;

  always_ff @(posedge clk_usb or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      bcnt_q      <= '0;
      size_q      <= '0;
      datao_q     <= '0;
      dout_q      <= '0;
      isout_q     <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addrvalid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      size_q      <= size_d;
      datao_q     <= datao_d;
      dout_q      <= dout_d;
      isout_q     <= isout_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addrvalid_q <= addrvalid_d;
      armed_q     <= armed_d;
    end
  end

  // A write only qualifies if its wrn fall was seen in READY, so a write that
  // straddles an address latch is dropped.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    size_d  = size_q;
    datao_d = datao_q;
    dout_d  = dout_q;
    isout_d = isout_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    armed_d = armed_q;
    if (write_q) bcnt_d = bcnt_q + BCNT_WIDTH'(1);
    if (cen_s) begin
      state_d = IDLE;
      isout_d = 1'b0;
      armed_d = 1'b0;
    end else if (!alen_s) begin
      addr_d  = addr_s[ADDR_WIDTH-1:0];
      size_d  = bus.reg_hyplen;
      bcnt_d  = '0;
      isout_d = 1'b0;
      armed_d = 1'b0;
      state_d = READY;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        READY: begin
          if (wr_fall) armed_d = 1'b1;
          if (!rdn_s && !wrn_s) begin
            armed_d = 1'b0;
          end else if (wr_rise && armed_q && rdn_s) begin
            datao_d = din_s;
            armed_d = 1'b0;
            state_d = WR_STB;
          end else if (rd_fall) begin
            state_d = RD_STB;
          end
        end
        WR_STB: begin
          write_d = 1'b1;
          state_d = READY;
        end
        RD_STB: begin
          read_d  = 1'b1;
          state_d = RD_HOLD;
        end
        RD_HOLD: begin
          if (read_q) begin
            dout_d  = bus.reg_datai;
            isout_d = 1'b1;
          end
          if (rd_rise) begin
            isout_d = 1'b0;
            bcnt_d  = bcnt_q + BCNT_WIDTH'(1);
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    addrvalid_d = (state_d != IDLE);
  end

  assign bus.usb_dout       = dout_q;
  assign bus.usb_isout      = isout_q;
  assign bus.reg_address    = addr_q;
  assign bus.reg_bytecnt    = bcnt_q;
  assign bus.reg_datao      = datao_q;
  assign bus.reg_read       = read_q;
  assign bus.reg_write      = write_q;
  assign bus.reg_addrvalid  = addrvalid_q;
  assign bus.reg_hypaddress = addr_s[ADDR_WIDTH-1:0];
  assign bus.reg_size       = size_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_usb_reg_bridge.sv
// Bench for usb_reg_bridge: host-bus driver tasks, a transaction-level model of the
// register bus, and a strobe monitor checked against expected queues.
module tb_usb_reg_bridge;
  localparam int S  = 2;
  localparam int AW = 6;
  localparam int BW = 10;

  logic       clk_usb;
  logic       reset_n;
  logic [2:0] dbg_state;
  int         cyc;
  int         n_checks;
  int         n_errors;

  usb_reg_bridge_if #(.ADDR_WIDTH(AW), .BCNT_WIDTH(BW)) bus ();

  usb_reg_bridge #(.SYNC_STAGES(S), .ADDR_WIDTH(AW), .BCNT_WIDTH(BW)) dut (
    .clk_usb     (clk_usb),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;
  initial cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  // reference model of the register-bus view
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bcnt;
  logic [7:0]    salt;
  logic [31:0]   exp_wr_q[$];
  int            exp_wr_cyc_q[$];
  logic [31:0]   exp_rd_q[$];
  int            exp_rd_cyc_q[$];

  // slaves return a byte derived from the current byte index
  assign bus.reg_datai = bus.reg_bytecnt[7:0] + salt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_usb);
      #1;
    end
  endtask

  // scoreboard: every strobe pulse must match the head of its expected queue
  logic prev_wr, prev_rd;
  initial begin
    prev_wr = 1'b0;
    prev_rd = 1'b0;
  end
  always @(posedge clk_usb) begin
    #1;
    if (prev_wr) check("wr_gap", {31'b0, bus.reg_write}, 32'd0);
    if (prev_rd) check("rd_gap", {31'b0, bus.reg_read}, 32'd0);
    if (bus.reg_write) begin
      if (exp_wr_q.size() == 0) check("wr_unexpected", {31'b0, bus.reg_write}, 32'd0);
      else begin
        check("wr_fields", {2'b00, bus.reg_address, 16'(bus.reg_bytecnt), bus.reg_datao},
              exp_wr_q.pop_front());
        check("wr_latency", cyc, exp_wr_cyc_q.pop_front());
      end
    end
    if (bus.reg_read) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", {31'b0, bus.reg_read}, 32'd0);
      else begin
        check("rd_fields", {2'b00, bus.reg_address, 16'(bus.reg_bytecnt), 8'h00},
              exp_rd_q.pop_front());
        check("rd_latency", cyc, exp_rd_cyc_q.pop_front());
      end
    end
    prev_wr = bus.reg_write;
    prev_rd = bus.reg_read;
  end

  // driver tasks
  task automatic do_ale(input logic [7:0] addr, input logic [15:0] hyplen);
    bus.usb_addr   = addr;
    bus.reg_hyplen = hyplen;
    wait_cyc(S + 3);
    check("hypaddress", 32'(bus.reg_hypaddress), 32'(addr[AW-1:0]));
    bus.usb_alen = 1'b0;
    wait_cyc(S + 3);
    bus.usb_alen = 1'b1;
    wait_cyc(S + 3);
    m_addr = addr[AW-1:0];
    m_bcnt = '0;
    check("ale_address", 32'(bus.reg_address), 32'(m_addr));
    check("ale_size", 32'(bus.reg_size), 32'(hyplen));
    check("ale_bytecnt", 32'(bus.reg_bytecnt), 32'd0);
    check("ale_addrvalid", {31'b0, bus.reg_addrvalid}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] data);
    bus.usb_din = data;
    bus.usb_wrn = 1'b0;
    wait_cyc(S + 3);
    bus.usb_wrn = 1'b1;
    exp_wr_q.push_back({2'b00, m_addr, 16'(m_bcnt), data});
    exp_wr_cyc_q.push_back(cyc + S + 2);
    m_bcnt = m_bcnt + 1'b1;
    wait_cyc(S + 4);
    check("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(m_bcnt));
  endtask

  task automatic rd_start();
    check("rd_isout_before", {31'b0, bus.usb_isout}, 32'd0);
    bus.usb_rdn = 1'b0;
    exp_rd_q.push_back({2'b00, m_addr, 16'(m_bcnt), 8'h00});
    exp_rd_cyc_q.push_back(cyc + S + 2);
    wait_cyc(S + 3);
    check("rd_isout", {31'b0, bus.usb_isout}, 32'd1);
    check("rd_dout", 32'(bus.usb_dout), 32'(8'(m_bcnt[7:0] + salt)));
  endtask

  task automatic rd_finish();
    wait_cyc(2);
    bus.usb_rdn = 1'b1;
    wait_cyc(S + 2);
    check("rd_isout_release", {31'b0, bus.usb_isout}, 32'd0);
    m_bcnt = m_bcnt + 1'b1;
    wait_cyc(2);
    check("rd_bytecnt", 32'(bus.reg_bytecnt), 32'(m_bcnt));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_addr = '0;
    m_bcnt = '0;
    salt = 8'h00;
    bus.usb_addr = 8'h00;
    bus.usb_din = 8'h00;
    bus.usb_rdn = 1'b1;
    bus.usb_wrn = 1'b1;
    bus.usb_cen = 1'b1;
    bus.usb_alen = 1'b1;
    bus.reg_hyplen = 16'h0000;
    reset_n = 1'b0;
    wait_cyc(3);
    check("rst_dout", 32'(bus.usb_dout), 32'd0);
    check("rst_isout", {31'b0, bus.usb_isout}, 32'd0);
    check("rst_strobes", {30'b0, bus.reg_read, bus.reg_write}, 32'd0);
    check("rst_addrvalid", {31'b0, bus.reg_addrvalid}, 32'd0);
    check("rst_addr_bcnt", {16'(bus.reg_address), 16'(bus.reg_bytecnt)}, 32'd0);
    check("rst_size_datao", {bus.reg_size, 8'h00, bus.reg_datao}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(4);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    bus.usb_cen = 1'b0;
    wait_cyc(S + 2);
    check("cen_low_no_ale", {31'b0, bus.reg_addrvalid}, 32'd0);

    // two writes at 0x15
    do_ale(8'h15, 16'($urandom));
    do_write(8'hA5);
    do_write(8'h3C);

    // three reads at 0x04; slave data 0x10 + bytecnt
    salt = 8'h10;
    do_ale(8'h04, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      rd_start();
      rd_finish();
    end

    // randomized transfers
    for (int r = 0; r < 5; r++) begin
      salt = 8'($urandom);
      do_ale(8'($urandom_range(0, 255)), 16'($urandom));
      for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
        if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
        else begin
          rd_start();
          rd_finish();
        end
      end
    end

    // cen raised while the read data is being driven
    rd_start();
    bus.usb_cen = 1'b1;
    wait_cyc(S + 2);
    check("cen_isout", {31'b0, bus.usb_isout}, 32'd0);
    check("cen_state_idle", 32'(dbg_state), 32'd0);
    check("cen_addrvalid", {31'b0, bus.reg_addrvalid}, 32'd0);
    check("cen_keep", {16'(bus.reg_address), 16'(bus.reg_bytecnt)}, {16'(m_addr), 16'(m_bcnt)});
    bus.usb_rdn = 1'b1;
    wait_cyc(S + 4);
    bus.usb_cen = 1'b0;
    wait_cyc(S + 2);

    // rdn and wrn low together: bus error, no strobes
    do_ale(8'($urandom), 16'($urandom));
    bus.usb_rdn = 1'b0;
    bus.usb_wrn = 1'b0;
    wait_cyc(S + 4);
    bus.usb_rdn = 1'b1;
    bus.usb_wrn = 1'b1;
    wait_cyc(S + 4);
    check("buserr_bytecnt", 32'(bus.reg_bytecnt), 32'(m_bcnt));
    check("buserr_isout", {31'b0, bus.usb_isout}, 32'd0);

    // address latch while wrn is low discards that write
    do_write(8'h5A);
    bus.usb_wrn = 1'b0;
    wait_cyc(S + 3);
    do_ale(8'h2B, 16'h00FF);
    bus.usb_wrn = 1'b1;
    wait_cyc(S + 5);
    check("ale_wr_bytecnt", 32'(bus.reg_bytecnt), 32'd0);
    check("ale_wr_address", 32'(bus.reg_address), 32'h2B);

    // byte counter wraps from all-ones to zero
    do_ale(8'($urandom), 16'($urandom));
    for (int i = 0; i < (1 << BW) - 1; i++) do_write(8'($urandom));
    check("bcnt_allones", 32'(bus.reg_bytecnt), 32'((1 << BW) - 1));
    do_write(8'($urandom));
    check("bcnt_wrap", 32'(bus.reg_bytecnt), 32'd0);

    // reset in the middle of a read
    salt = 8'($urandom);
    rd_start();
    reset_n = 1'b0;
    #1;
    check("rstrd_isout", {31'b0, bus.usb_isout}, 32'd0);
    check("rstrd_addrvalid", {31'b0, bus.reg_addrvalid}, 32'd0);
    check("rstrd_strobes", {30'b0, bus.reg_read, bus.reg_write}, 32'd0);
    bus.usb_rdn = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(S + 4);
    check("rstrd_state_idle", 32'(dbg_state), 32'd0);
    check("rstrd_addr_bcnt", {16'(bus.reg_address), 16'(bus.reg_bytecnt)}, 32'd0);
    check("rstrd_idle_valid", {31'b0, bus.reg_addrvalid}, 32'd0);

    wait_cyc(4);
    check("wr_missing", exp_wr_q.size(), 32'd0);
    check("rd_missing", exp_rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
